// File: rtl/uart_rx_deser.sv
// ---------------------------------------------------------------------------
// uart_rx_deser
//   Serial-to-parallel UART receiver, 8N1, LSB first.
//   The RXD line is synchronised through two flops. Every bit is sampled at
//   mid-period. Each received byte goes to the consumer over a valid/ack
//   handshake. Framing and overrun errors are flagged with one-cycle pulses.
//
// Ports
//   Clk            in   1  system clock, rising edge
//   Rst            in   1  synchronous reset, active high
//   RXD            in   1  asynchronous serial input, idle high
//   Data_Out       out  8  last received byte
//   Data_Valid     out  1  byte available, held until acknowledged
//   Data_Ack       in   1  consumer takes Data_Out (only while Data_Valid=1)
//   Framing_Error  out  1  1-cycle pulse: stop bit sampled low
//   Overrun        out  1  1-cycle pulse: new byte replaced an unacked one
//   Busy           out  1  receiver FSM not idle
// ---------------------------------------------------------------------------
module uart_rx_deser #(
  parameter int FREQ_CLK = 100000000,
  parameter int TX_SPEED = 115200
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       RXD,
  output logic [7:0] Data_Out,
  output logic       Data_Valid,
  input  logic       Data_Ack,
  output logic       Framing_Error,
  output logic       Overrun,
  output logic       Busy
);

  localparam int BIT_CYCLES = FREQ_CLK / TX_SPEED;
  localparam int HALF       = BIT_CYCLES / 2;
  localparam int CNT_W      = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  // Two-flop synchroniser. Both flops reset to the idle level so that reset
  // cannot look like a start edge.
  logic             sync1_q, sync1_d;
  logic             rx_s_q,  rx_s_d;

  logic [2:0]       state_q,    state_d;
  logic [CNT_W-1:0] bit_cnt_q,  bit_cnt_d;
  logic [2:0]       idx_q,      idx_d;
  logic [7:0]       shreg_q,    shreg_d;
  logic [7:0]       data_out_q, data_out_d;
  logic             valid_q,    valid_d;
  logic             fe_q,       fe_d;
  logic             ovr_q,      ovr_d;

  always_comb begin
    sync1_d    = RXD;
    rx_s_d     = sync1_q;

    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    idx_d      = idx_q;
    shreg_d    = shreg_q;
    data_out_d = data_out_q;
    fe_d       = 1'b0;
    ovr_d      = 1'b0;

    // The handshake completes on the edge where valid and ack are both high.
    // A stop-bit load in the same cycle overrides this below.
    valid_d    = valid_q && !Data_Ack;

    case (state_q)
      S_IDLE: begin
        bit_cnt_d = '0;
        if (!rx_s_q) state_d = S_START;
      end

      // Re-check the line half a bit after the falling edge. A pulse shorter
      // than that is treated as noise.
      S_START: begin
        if (bit_cnt_q == CNT_HALF) begin
          bit_cnt_d = '0;
          if (!rx_s_q) begin
            state_d = S_DATA;
            idx_d   = 3'd0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_ONE;
        end
      end

      // The counter is already aligned to mid-bit, so each full bit period
      // from here on lands in the centre of the next bit.
      S_DATA: begin
        if (bit_cnt_q == CNT_LAST) begin
          bit_cnt_d       = '0;
          shreg_d[idx_q]  = rx_s_q;
          if (idx_q == 3'd7) state_d = S_STOP;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_ONE;
        end
      end

      // Returning to IDLE at mid stop bit leaves half a bit to catch the next
      // start edge from a sender that leaves no gap between frames.
      S_STOP: begin
        if (bit_cnt_q == CNT_LAST) begin
          bit_cnt_d = '0;
          if (rx_s_q) begin
            data_out_d = shreg_q;
            valid_d    = 1'b1;
            ovr_d      = valid_q && !Data_Ack;
            state_d    = S_IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_ONE;
        end
      end

      // A line held low after a bad stop bit must not be taken as a new start.
      S_BREAK: begin
        bit_cnt_d = '0;
        if (rx_s_q) state_d = S_IDLE;
      end

      default: begin
        state_d   = S_IDLE;
        bit_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      sync1_q    <= 1'b1;
      rx_s_q     <= 1'b1;
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      idx_q      <= 3'd0;
      shreg_q    <= 8'd0;
      data_out_q <= 8'd0;
      valid_q    <= 1'b0;
      fe_q       <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      rx_s_q     <= rx_s_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      idx_q      <= idx_d;
      shreg_q    <= shreg_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      fe_q       <= fe_d;
      ovr_q      <= ovr_d;
    end
  end

  assign Data_Out      = data_out_q;
  assign Data_Valid    = valid_q;
  assign Framing_Error = fe_q;
  assign Overrun       = ovr_q;
  assign Busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_deser.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_deser
//   Bench for uart_rx_deser. It uses a short bit period. A serial driver
//   sends frames. A reference model records the expected bytes and error
//   counts. A monitor/ack process collects what the receiver presents.
// ---------------------------------------------------------------------------
module tb_uart_rx_deser;
  localparam int FREQ = 100000000;
  localparam int SPEED = 1000000;
  localparam int BC   = FREQ / SPEED;        // clocks per bit
  localparam int HALF = BC / 2;
  localparam int LAT  = 3 + HALF + 9 * BC;   // start edge to Data_Valid

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       RXD = 1'b1;
  logic       Data_Ack = 1'b0;
  logic [7:0] Data_Out;
  logic       Data_Valid, Framing_Error, Overrun, Busy;

  uart_rx_deser #(.FREQ_CLK(FREQ), .TX_SPEED(SPEED)) dut (
    .Clk(Clk), .Rst(Rst), .RXD(RXD), .Data_Out(Data_Out),
    .Data_Valid(Data_Valid), .Data_Ack(Data_Ack),
    .Framing_Error(Framing_Error), .Overrun(Overrun), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---- reference model ----------------------------------------------------
  logic [7:0] exp_q[$];
  int         exp_fe = 0, exp_ov = 0;
  bit         pend = 0;       // a byte is presented and not yet acknowledged
  bit         auto_ack = 0;

  task automatic model_frame(input logic [7:0] b, input int stop_low);
    if (stop_low != 0) exp_fe++;
    else begin
      exp_q.push_back(b);
      if (pend && !auto_ack) exp_ov++;
      pend = !auto_ack;
    end
  endtask

  // ---- monitor + auto-ack -------------------------------------------------
  logic [7:0] rx_q[$];
  int fe_cnt = 0, ov_cnt = 0, hs_cnt = 0, rise_cyc = 0;
  bit dv_prev = 0;

  initial begin
    forever begin
      @(negedge Clk);
      if (Data_Valid === 1'b1 && !dv_prev) begin
        rx_q.push_back(Data_Out);
        rise_cyc = cyc;
      end else if (Overrun === 1'b1) begin
        rx_q.push_back(Data_Out);
      end
      if (Framing_Error === 1'b1) fe_cnt++;
      if (Overrun === 1'b1) ov_cnt++;
      dv_prev = (Data_Valid === 1'b1);
      if (auto_ack) Data_Ack = (Data_Valid === 1'b1) && (Data_Ack === 1'b0);
      if (Data_Valid === 1'b1 && Data_Ack === 1'b1) hs_cnt++;
    end
  end

  // ---- driver ---------------------------------------------------------------
  // All driver tasks start and end at 1 time unit after a rising edge.
  task automatic drive(input logic v, input int n);
    RXD = v;
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input int stop_low);
    drive(1'b0, BC);
    for (int i = 0; i < 8; i++) drive(b[i], BC);
    if (stop_low == 0) drive(1'b1, BC);
    else begin
      drive(1'b0, stop_low * BC);
      drive(1'b1, BC);
    end
  endtask

  task automatic xfer(input logic [7:0] b, input int stop_low);
    model_frame(b, stop_low);
    send_frame(b, stop_low);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (Busy !== 1'b0 && n < 4 * BC) begin
      cycles(1);
      n++;
    end
    chk({tag, "_idle"}, Busy, 1'b0);
  endtask

  task automatic cmp_bytes(input string tag);
    chk({tag, "_count"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      chk({tag, "_byte"}, rx_q[i], exp_q[i]);
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_start, h0, g, n;
    logic [7:0] b6, rb;

    // reset
    cycles(3);
    Rst = 1'b0;
    chk("rst_data", Data_Out, 8'h00);
    chk("rst_valid", Data_Valid, 1'b0);
    chk("rst_fe", Framing_Error, 1'b0);
    chk("rst_ovr", Overrun, 1'b0);
    chk("rst_busy", Busy, 1'b0);
    cycles(5);

    // T1: single byte, exact latency, value held until ack
    auto_ack = 0;
    t_start = cyc;
    xfer(8'hAB, 0);
    wait_idle("t1");
    chk("t1_latency", rise_cyc - t_start, LAT);
    chk("t1_data", Data_Out, 8'hAB);
    chk("t1_valid", Data_Valid, 1'b1);
    cycles(10);
    chk("t1_hold_data", Data_Out, 8'hAB);
    chk("t1_hold_valid", Data_Valid, 1'b1);
    Data_Ack = 1'b1;
    cycles(1);
    Data_Ack = 1'b0;
    pend = 0;
    chk("t1_ack_clear", Data_Valid, 1'b0);
    chk("t1_fe", fe_cnt, exp_fe);
    chk("t1_ovr", ov_cnt, exp_ov);
    cmp_bytes("t1");

    // T2: back-to-back frames with prompt acks
    auto_ack = 1;
    h0 = hs_cnt;
    xfer(8'hAB, 0);
    xfer(8'hCD, 0);
    wait_idle("t2");
    cycles(3);
    chk("t2_handshakes", hs_cnt - h0, 2);
    chk("t2_valid", Data_Valid, 1'b0);
    cmp_bytes("t2");

    // T3: short low pulse is rejected
    g = $urandom_range(HALF - 5, 5);
    drive(1'b0, g);
    chk("t3_busy_hi", Busy, 1'b1);
    RXD = 1'b1;
    n = 0;
    while (Busy !== 1'b0 && n < HALF + 3) begin
      cycles(1);
      n++;
    end
    chk("t3_busy_lo", Busy, 1'b0);
    cycles(2 * BC);
    chk("t3_no_bytes", rx_q.size(), 0);
    chk("t3_valid", Data_Valid, 1'b0);

    // T4: bad stop bit held low two bit times, then a good frame
    xfer(8'h55, 2);
    chk("t4_valid", Data_Valid, 1'b0);
    chk("t4_fe", fe_cnt, exp_fe);
    xfer(8'h3C, 0);
    wait_idle("t4");
    cycles(3);
    cmp_bytes("t4");
    chk("t4_fe_total", fe_cnt, exp_fe);

    // T5: two bytes without ack -> overrun
    auto_ack = 0;
    Data_Ack = 1'b0;
    xfer(8'h11, 0);
    xfer(8'h22, 0);
    wait_idle("t5");
    chk("t5_ovr", ov_cnt, exp_ov);
    chk("t5_data", Data_Out, 8'h22);
    chk("t5_valid", Data_Valid, 1'b1);
    Data_Ack = 1'b1;
    cycles(1);
    Data_Ack = 1'b0;
    pend = 0;
    chk("t5_ack_clear", Data_Valid, 1'b0);
    cmp_bytes("t5");
    auto_ack = 1;

    // T6: reset during data bit 4 aborts the frame. Bits 4..7 are high, so
    // the rest of the frame leaves the line idle.
    b6 = 8'hF0 | 8'($urandom_range(15, 0));
    fork
      send_frame(b6, 0);
      begin
        cycles(5 * BC + HALF);
        chk("t6_busy_pre", Busy, 1'b1);
        Rst = 1'b1;
        cycles(1);
        Rst = 1'b0;
        chk("t6_rst_data", Data_Out, 8'h00);
        chk("t6_rst_valid", Data_Valid, 1'b0);
        chk("t6_rst_fe", Framing_Error, 1'b0);
        chk("t6_rst_ovr", Overrun, 1'b0);
        chk("t6_rst_busy", Busy, 1'b0);
      end
    join
    wait_idle("t6a");
    cycles(5);
    chk("t6_no_bytes", rx_q.size(), 0);
    chk("t6_fe", fe_cnt, exp_fe);
    xfer(8'hA5, 0);
    wait_idle("t6b");
    cycles(3);
    cmp_bytes("t6");

    // random traffic: random bytes, gaps and occasional bad stop bits
    for (int k = 0; k < 10; k++) begin
      rb = 8'($urandom);
      if ($urandom_range(3, 0) == 0) xfer(rb, int'($urandom_range(2, 1)));
      else                           xfer(rb, 0);
      g = $urandom_range(BC, 0);
      if (g != 0) drive(1'b1, g);
    end
    wait_idle("rnd");
    cycles(5);
    cmp_bytes("rnd");
    chk("rnd_fe", fe_cnt, exp_fe);
    chk("rnd_ovr", ov_cnt, exp_ov);
    chk("rnd_valid", Data_Valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
